// File: rtl/password_checker_pkg.sv
// Shared definitions for the password checker slice.
//   MAX_BYTES_DEF : default maximum password length in bytes
//   state_t       : checker FSM states
//   clamp_len()   : limits a requested length to the bus capacity
package password_checker_pkg;

   localparam int MAX_BYTES_DEF = 16;

   // Largest target length accepted with the default bus width.
   localparam logic [7:0] LEN_CLAMP_DEF = 8'(MAX_BYTES_DEF);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEARCH    = 2'd1,
      FOUND     = 2'd2,
      EXHAUSTED = 2'd3
   } state_t;

   function automatic logic [7:0] clamp_len(input logic [7:0] len,
                                            input logic [7:0] max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/password_compare.sv
// Byte-masked equality of two password words.
//   a, b   : 8*MAX_BYTES words, byte 0 in bits [7:0]
//   length : number of significant bytes; bytes at or above it are ignored
//   equal  : 1 when every significant byte matches exactly
module password_compare #(
   parameter int MAX_BYTES = password_checker_pkg::MAX_BYTES_DEF
) (
   input  logic [8*MAX_BYTES-1:0] a,
   input  logic [8*MAX_BYTES-1:0] b,
   input  logic [7:0]             length,
   output logic                   equal
);

   logic [MAX_BYTES-1:0] byte_eq;

   for (genvar i = 0; i < MAX_BYTES; i++) begin : g_byte
      // A masked-off byte always counts as equal.
      assign byte_eq[i] = (length <= 8'(i)) || (a[8*i +: 8] == b[8*i +: 8]);
   end

   assign equal = &byte_eq;

endmodule

// File: rtl/password_checker.sv
// Candidate password checker.
//   target_load/target_password/target_length : target capture (IDLE only)
//   max_attempts/start                        : limit and search launch (IDLE only)
//   clear                                     : FOUND/EXHAUSTED back to IDLE
//   cand_valid/cand_password/cand_ready       : candidate stream handshake
//   busy/found/exhausted                      : state flags
//   match_password/attempt_count              : result of the search
// Accepted candidates land in a one-entry stage and are compared on the next
// edge, so results appear one cycle after acceptance.
module password_checker
   import password_checker_pkg::*;
#(
   parameter int MAX_BYTES = MAX_BYTES_DEF,
   parameter int CNT_W     = 32
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   target_load,
   input  logic [8*MAX_BYTES-1:0] target_password,
   input  logic [7:0]             target_length,
   input  logic [CNT_W-1:0]       max_attempts,
   input  logic                   start,
   input  logic                   clear,
   input  logic                   cand_valid,
   input  logic [8*MAX_BYTES-1:0] cand_password,
   output logic                   cand_ready,
   output logic                   busy,
   output logic                   found,
   output logic                   exhausted,
   output logic [8*MAX_BYTES-1:0] match_password,
   output logic [CNT_W-1:0]       attempt_count
);

   state_t                 state, state_n;
   logic [8*MAX_BYTES-1:0] target;
   logic [7:0]             tlen;
   logic [CNT_W-1:0]       limit;
   logic [CNT_W-1:0]       accepted;
   logic                   stage_vld;
   logic [8*MAX_BYTES-1:0] stage_pw;
   logic                   stage_eq;
   logic                   go;
   logic                   accept;
   logic                   hit;
   logic                   last;

   password_compare #(.MAX_BYTES(MAX_BYTES)) u_cmp (
      .a      (stage_pw),
      .b      (target),
      .length (tlen),
      .equal  (stage_eq)
   );

   assign go         = (state == IDLE) && start && (tlen != 8'd0) && (max_attempts != '0);
   assign cand_ready = (state == SEARCH) && (accepted < limit);
   assign accept     = cand_valid && cand_ready;
   assign hit        = stage_vld && stage_eq;
   // Comparing the final permitted attempt; no further candidate can follow.
   assign last       = stage_vld && ((attempt_count + CNT_W'(1)) == limit);

   assign busy      = (state == SEARCH);
   assign found     = (state == FOUND);
   assign exhausted = (state == EXHAUSTED);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:      if (go) state_n = SEARCH;
         SEARCH: begin
            if (hit)       state_n = FOUND;   // match wins over the limit
            else if (last) state_n = EXHAUSTED;
         end
         FOUND,
         EXHAUSTED: if (clear) state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         target         <= '0;
         tlen           <= '0;
         limit          <= '0;
         accepted       <= '0;
         stage_vld      <= 1'b0;
         stage_pw       <= '0;
         match_password <= '0;
         attempt_count  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (target_load) begin
                  target <= target_password;
                  tlen   <= clamp_len(target_length, 8'(MAX_BYTES));
               end
               if (go) begin
                  limit          <= max_attempts;
                  accepted       <= '0;
                  attempt_count  <= '0;
                  match_password <= '0;
                  stage_vld      <= 1'b0;
               end
            end
            SEARCH: begin
               if (accept) begin
                  accepted <= accepted + CNT_W'(1);
                  stage_pw <= cand_password;
               end
               stage_vld <= accept;
               if (stage_vld) begin
                  attempt_count <= attempt_count + CNT_W'(1);
                  if (hit) begin
                     match_password <= stage_pw;
                     // The candidate accepted alongside the match is dropped.
                     stage_vld      <= 1'b0;
                  end
               end
            end
            FOUND,
            EXHAUSTED: if (clear) stage_vld <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_password_checker.sv
module tb_password_checker;

   localparam int MB = 16;
   localparam int CW = 32;

   logic            clock = 1'b0;
   logic            reset_n;
   logic            target_load;
   logic [8*MB-1:0] target_password;
   logic [7:0]      target_length;
   logic [CW-1:0]   max_attempts;
   logic            start;
   logic            clear;
   logic            cand_valid;
   logic [8*MB-1:0] cand_password;
   logic            cand_ready;
   logic            busy;
   logic            found;
   logic            exhausted;
   logic [8*MB-1:0] match_password;
   logic [CW-1:0]   attempt_count;

   password_checker #(.MAX_BYTES(MB), .CNT_W(CW)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .target_load     (target_load),
      .target_password (target_password),
      .target_length   (target_length),
      .max_attempts    (max_attempts),
      .start           (start),
      .clear           (clear),
      .cand_valid      (cand_valid),
      .cand_password   (cand_password),
      .cand_ready      (cand_ready),
      .busy            (busy),
      .found           (found),
      .exhausted       (exhausted),
      .match_password  (match_password),
      .attempt_count   (attempt_count)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0]           len;
      logic [127:0]         tgt;
      logic [31:0]          limit;
      logic [3:0]           ncand;
      logic [7:0][127:0]    cands;
      logic                 exp_found;
      logic                 exp_exh;
      logic [31:0]          exp_cnt;
      logic [31:0]          exp_acc;
      logic [127:0]         exp_match;
   } vec_t;

   vec_t vecs [7];
   vec_t sb [$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic load_and_start(input logic [127:0] t, input logic [7:0] l, input logic [31:0] lim);
      target_load = 1'b1; target_password = t; target_length = l;
      step();
      target_load = 1'b0;
      max_attempts = lim; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic run_vec(input int v);
      vec_t e;
      int   idx, done_cyc;
      int   acc_cyc [9];
      bit   acc, done;
      load_and_start(vecs[v].tgt, vecs[v].len, vecs[v].limit);
      chk($sformatf("v%0d busy after start", v), 128'(busy), 128'(1));
      chk($sformatf("v%0d ready after start", v), 128'(cand_ready), 128'(1));
      sb.push_back(vecs[v]);
      idx = 0; done = 0; done_cyc = 0;
      for (int c = 0; c < 64 && !done; c++) begin
         cand_valid    = (idx < int'(vecs[v].ncand));
         cand_password = (idx < 8) ? vecs[v].cands[idx] : '0;
         acc = cand_valid && cand_ready;
         step();
         if (acc) begin acc_cyc[idx] = cyc; idx++; end
         if (found || exhausted) begin done = 1; done_cyc = cyc; end
      end
      cand_valid = 1'b0;
      e = sb.pop_front();
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL v%0d timeout: got no result expected found/exhausted", v);
         return;
      end
      chk($sformatf("v%0d found", v), 128'(found), 128'(e.exp_found));
      chk($sformatf("v%0d exhausted", v), 128'(exhausted), 128'(e.exp_exh));
      chk($sformatf("v%0d attempt_count", v), 128'(attempt_count), 128'(e.exp_cnt));
      chk($sformatf("v%0d accepts", v), 128'(idx), 128'(e.exp_acc));
      chk($sformatf("v%0d latency", v), 128'(done_cyc - acc_cyc[e.exp_cnt - 1]), 128'(1));
      if (e.exp_found) chk($sformatf("v%0d match_password", v), match_password, e.exp_match);
      step(); step();
      chk($sformatf("v%0d hold flags", v), 128'({found, exhausted, cand_ready}),
          128'({e.exp_found, e.exp_exh, 1'b0}));
      chk($sformatf("v%0d hold count", v), 128'(attempt_count), 128'(e.exp_cnt));
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk($sformatf("v%0d after clear flags", v), 128'({busy, found, exhausted}), 128'(0));
      chk($sformatf("v%0d count kept", v), 128'(attempt_count), 128'(e.exp_cnt));
   endtask

   initial begin
      // "ab" found on 2nd of two back-to-back candidates
      vecs[0] = '0; vecs[0].len = 2; vecs[0].tgt = 128'h6261; vecs[0].limit = 100;
      vecs[0].ncand = 2; vecs[0].cands[0] = 128'h6161; vecs[0].cands[1] = 128'h6261;
      vecs[0].exp_found = 1; vecs[0].exp_cnt = 2; vecs[0].exp_acc = 2; vecs[0].exp_match = 128'h6261;
      // length 1: byte 1 of "cz" is ignored
      vecs[1] = '0; vecs[1].len = 1; vecs[1].tgt = 128'h63; vecs[1].limit = 10;
      vecs[1].ncand = 1; vecs[1].cands[0] = 128'h7A63;
      vecs[1].exp_found = 1; vecs[1].exp_cnt = 1; vecs[1].exp_acc = 1; vecs[1].exp_match = 128'h7A63;
      // limit 3, never matches, extra candidates offered but refused
      vecs[2] = '0; vecs[2].len = 2; vecs[2].tgt = 128'h6261; vecs[2].limit = 3;
      vecs[2].ncand = 5; vecs[2].cands[0] = 128'h78; vecs[2].cands[1] = 128'h79;
      vecs[2].cands[2] = 128'h7A; vecs[2].cands[3] = 128'h77; vecs[2].cands[4] = 128'h6261;
      vecs[2].exp_exh = 1; vecs[2].exp_cnt = 3; vecs[2].exp_acc = 3;
      // limit 3, match on the last allowed attempt
      vecs[3] = '0; vecs[3].len = 2; vecs[3].tgt = 128'h6261; vecs[3].limit = 3;
      vecs[3].ncand = 3; vecs[3].cands[0] = 128'h78; vecs[3].cands[1] = 128'h79;
      vecs[3].cands[2] = 128'h6261;
      vecs[3].exp_found = 1; vecs[3].exp_cnt = 3; vecs[3].exp_acc = 3; vecs[3].exp_match = 128'h6261;
      // match on 5th; 6th (also matching) accepted with the match and discarded
      vecs[4] = '0; vecs[4].len = 2; vecs[4].tgt = 128'h6261; vecs[4].limit = 100;
      vecs[4].ncand = 6; vecs[4].cands[0] = 128'h31; vecs[4].cands[1] = 128'h32;
      vecs[4].cands[2] = 128'h33; vecs[4].cands[3] = 128'h34; vecs[4].cands[4] = 128'h6261;
      vecs[4].cands[5] = 128'h516261;
      vecs[4].exp_found = 1; vecs[4].exp_cnt = 5; vecs[4].exp_acc = 6; vecs[4].exp_match = 128'h6261;
      // length 20 clamps to 16; top byte difference must be seen
      vecs[5] = '0; vecs[5].len = 20; vecs[5].tgt = 128'h0F0E0D0C0B0A09080706050403020100;
      vecs[5].limit = 4; vecs[5].ncand = 2;
      vecs[5].cands[0] = 128'hFF0E0D0C0B0A09080706050403020100;
      vecs[5].cands[1] = 128'h0F0E0D0C0B0A09080706050403020100;
      vecs[5].exp_found = 1; vecs[5].exp_cnt = 2; vecs[5].exp_acc = 2;
      vecs[5].exp_match = 128'h0F0E0D0C0B0A09080706050403020100;
      // no case folding: "a" does not match "A"
      vecs[6] = '0; vecs[6].len = 1; vecs[6].tgt = 128'h41; vecs[6].limit = 5;
      vecs[6].ncand = 2; vecs[6].cands[0] = 128'h61; vecs[6].cands[1] = 128'h41;
      vecs[6].exp_found = 1; vecs[6].exp_cnt = 2; vecs[6].exp_acc = 2; vecs[6].exp_match = 128'h41;

      reset_n = 1'b0; target_load = 0; target_password = '0; target_length = 0;
      max_attempts = 0; start = 0; clear = 0; cand_valid = 0; cand_password = '0;
      #12;
      chk("reset flags", 128'({cand_ready, busy, found, exhausted}), 128'(0));
      chk("reset match_password", match_password, 128'(0));
      chk("reset attempt_count", 128'(attempt_count), 128'(0));
      reset_n = 1'b1;
      step();

      // start with stored length 0 is ignored
      max_attempts = 5; start = 1'b1; step(); start = 1'b0;
      chk("start len0 ignored", 128'(busy), 128'(0));
      // start with limit 0 is ignored
      load_and_start(128'h6261, 8'd2, 32'd0);
      chk("start limit0 ignored", 128'(busy), 128'(0));

      for (int v = 0; v < 7; v++) run_vec(v);

      // reset mid-search after 4 attempts
      load_and_start(128'h6261, 8'd2, 32'd100);
      cand_valid = 1'b1; cand_password = 128'h5A5A;
      for (int c = 0; c < 32 && attempt_count != 4; c++) step();
      chk("pre-reset attempt_count", 128'(attempt_count), 128'(4));
      reset_n = 1'b0;
      #2;
      chk("async reset flags", 128'({cand_ready, busy, found, exhausted}), 128'(0));
      chk("async reset outputs", match_password | 128'(attempt_count), 128'(0));
      cand_valid = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      max_attempts = 10; start = 1'b1; step(); start = 1'b0;
      chk("start after reset ignored", 128'(busy), 128'(0));
      load_and_start(128'h6261, 8'd2, 32'd10);
      chk("start after reload", 128'(busy), 128'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
